// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external one-clock simple-dual-port RAM (2-cycle read latency).
// Optional sticky overflow/underflow flags are enabled with macro SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl #(
    parameter int AW = 4,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_din,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout,
    output logic          ovf,
    output logic          udf
);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] wvis_q, wvis_d;
    logic [1:0]  rv_q, rv_d;
    logic        wr_acc, rd_acc;

    always_comb begin
        full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty  = (wvis_q == rptr_q);
        // Strobes are held low during reset so the RAM input registers flush.
        wr_acc = wr_en && !full && !rst;
        rd_acc = rd_en && !empty && !rst;
        wptr_d = wptr_q + {{AW{1'b0}}, wr_acc};
        rptr_d = rptr_q + {{AW{1'b0}}, rd_acc};
        // Visible write pointer lags so a word becomes readable once the RAM has committed it.
        wvis_d = wptr_q;
        rv_d   = {rv_q[0], rd_acc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            wvis_q <= '0;
            rv_q   <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            wvis_q <= wvis_d;
            rv_q   <= rv_d;
        end
    end

    assign ram_wen   = wr_acc;
    assign ram_waddr = wptr_q[AW-1:0];
    assign ram_din   = wr_data;
    assign ram_ren   = rd_acc;
    assign ram_raddr = rptr_q[AW-1:0];
    assign count     = wptr_q - rptr_q;
    assign rd_valid  = rv_q[1];
    assign rd_data   = ram_dout;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full);
        udf_d = udf_q | (rd_en & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule
